// File: rtl/alpha_fade_ctrl.sv
// Alpha ramp controller for the sprite blender: steps alpha between 0 and ALPHA_MAX
// once every FRAMES_PER_STEP frame pulses, with one-shot or ping-pong operation.
module alpha_fade_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 15,
  parameter int unsigned ALPHA_MAX       = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_frame_in,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       dir_in,
  input  logic       pingpong_in,
  output logic [2:0] alpha_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int unsigned     CntW     = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CntW-1:0] CntLast  = CntW'(FRAMES_PER_STEP - 1);
  localparam logic [2:0]      AlphaMax = 3'(ALPHA_MAX);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      alpha_q, alpha_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dir_q, dir_d;
  logic            pp_q, pp_d;

  logic [2:0]      alpha_step;
  logic            step_at_end;

  // dir_q = 1 ramps towards ALPHA_MAX, 0 towards 0
  always_comb begin
    alpha_step  = dir_q ? (alpha_q + 3'd1) : (alpha_q - 3'd1);
    step_at_end = dir_q ? (alpha_step == AlphaMax) : (alpha_step == 3'd0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    alpha_d = alpha_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    pp_d    = pp_q;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start_in) begin
          dir_d   = dir_in;
          pp_d    = pingpong_in;
          alpha_d = dir_in ? 3'd0 : AlphaMax;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop_in) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (new_frame_in) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            alpha_d = alpha_step;
            if (step_at_end) begin
              if (pp_q) begin
                dir_d = ~dir_q;
              end else begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StDone;
              end
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      alpha_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      pp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alpha_q <= alpha_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      pp_q    <= pp_d;
    end
  end

  assign alpha_out = alpha_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_alpha_fade_ctrl.sv
// Bench for alpha_fade_ctrl: two instances (FRAMES_PER_STEP 1 and 3) share stimulus;
// each cycle's expected outputs are queued when driven and checked after the edge.
module tb_alpha_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, dir, pingpong, new_frame;
  logic [2:0] a1, a3;
  logic       b1, b3, d1, d3;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       sel;
    logic [2:0] a;
    logic       b;
    logic       d;
    string      name;
  } exp_t;

  typedef struct {
    logic       r, s, p, dr, pp, nf;
    logic [2:0] a;
    logic       b, d;
    int         gap;
  } vec_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alpha_fade_ctrl #(.FRAMES_PER_STEP(1), .ALPHA_MAX(4)) dut1 (
    .clk_in(clk), .rst_in(rst), .new_frame_in(new_frame), .start_in(start),
    .stop_in(stop), .dir_in(dir), .pingpong_in(pingpong),
    .alpha_out(a1), .busy_out(b1), .done_out(d1)
  );

  alpha_fade_ctrl #(.FRAMES_PER_STEP(3), .ALPHA_MAX(4)) dut3 (
    .clk_in(clk), .rst_in(rst), .new_frame_in(new_frame), .start_in(start),
    .stop_in(stop), .dir_in(dir), .pingpong_in(pingpong),
    .alpha_out(a3), .busy_out(b3), .done_out(d3)
  );

  task automatic pop_check();
    exp_t       e;
    logic [2:0] ga;
    logic       gb, gd;
    e  = sb.pop_front();
    ga = e.sel ? a3 : a1;
    gb = e.sel ? b3 : b1;
    gd = e.sel ? d3 : d1;
    n_cmp++;
    if (ga !== e.a || gb !== e.b || gd !== e.d) begin
      n_err++;
      $display("FAIL %s: alpha/busy/done got %0d/%0b/%0b want %0d/%0b/%0b",
               e.name, ga, gb, gd, e.a, e.b, e.d);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
  task automatic cyc(input logic sel, input logic r, s, p, dr, pp, nf,
                     input logic [2:0] ea, input logic eb, ed, input string nm);
    exp_t e;
    rst = r; start = s; stop = p; dir = dr; pingpong = pp; new_frame = nf;
    e.sel = sel; e.a = ea; e.b = eb; e.d = ed; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; pingpong = 1'b0; new_frame = 1'b0;
    pop_check();
  endtask

  initial begin
    vec_t       tbl[7];
    logic [2:0] pp_seq[10];
    logic [2:0] ea;

    rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; pingpong = 1'b0; new_frame = 1'b0;
    @(posedge clk);
    #1;

    // One-shot fade up, FRAMES_PER_STEP=1, pulses 10 cycles apart
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 9};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 9};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 9};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 3};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].dr, tbl[i].pp, tbl[i].nf,
          tbl[i].a, tbl[i].b, tbl[i].d, $sformatf("up1_v%0d", i));
      for (int g = 0; g < tbl[i].gap; g++)
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tbl[i].a, tbl[i].b, 1'b0,
            $sformatf("up1_v%0d_gap%0d", i, g));
    end

    // One-shot fade down, FRAMES_PER_STEP=3
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "dn3_reset");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, "dn3_start");
    for (int i = 1; i <= 12; i++) begin
      ea = 3'(4 - i / 3);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ea, i < 12, i == 12,
          $sformatf("dn3_pulse%0d", i));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ea, i < 12, 1'b0,
          $sformatf("dn3_gap%0d", i));
    end

    // Ping-pong up, FRAMES_PER_STEP=1
    pp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "pp_reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, "pp_start");
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pp_seq[i], 1'b1, 1'b0,
          $sformatf("pp_pulse%0d", i + 1));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, "pp_stop");

    // Stop coinciding with a stepping pulse, then restart
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "stop_reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "stop_start");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, "stop_step1");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, "stop_step2");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, "stop_vs_step");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, "stop_idle_nf");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "stop_restart");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, "stop_restep");

    // Reset mid-fade at alpha 3
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "rst_reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "rst_start");
    for (int i = 1; i <= 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'(i), 1'b1, 1'b0,
          $sformatf("rst_step%0d", i));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "rst_midfade");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0,
          $sformatf("rst_nf_ignored%0d", i));

    // start held high through a whole one-shot fade
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "hold_reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "hold_start");
    for (int i = 1; i <= 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'(i), 1'b1, 1'b0,
          $sformatf("hold_step%0d", i));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, "hold_done");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, "hold_idle");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, "hold_refade");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, "hold_refade_step");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, "hold_stop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
